word_break: RTL

Reader-side serializer for the word buffer. It pops WORD_SIZE-bit words from the FIFO read port and breaks each one into WORD_SIZE/SLICE_SIZE narrow slices. Slices are sent least-significant first on a valid/ready stream. It sits between the buffer FIFO and the narrow downstream consumer, and is the counterpart of the join path that packs narrow data into words.

---
 rtl/word_break.sv | 94 +++++++++
 1 files changed

// File: rtl/word_break.sv
// word_break: reader-side serializer for the word buffer.
// Pops WORD_SIZE-bit words from a FIFO with 1-cycle read latency and emits
// them as WORD_SIZE/SLICE_SIZE slices, least-significant first, on a
// valid/ready stream.
//
// Handshake: a slice transfers on a rising edge where out_valid && out_ready.
// Once out_valid is high, out_data/out_last stay stable until that transfer.
// out_valid, out_last and out_data come only from registered state (gated by
// reset), never from out_ready or fifo_empty.
module word_break #(
    parameter int WORD_SIZE  = 32,
    parameter int SLICE_SIZE = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [WORD_SIZE-1:0]  fifo_data,
    output logic [SLICE_SIZE-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    localparam int RATIO = WORD_SIZE / SLICE_SIZE;
    localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [WORD_SIZE-1:0] sreg;
    logic [IDX_W-1:0]     idx;
    logic                 at_last;
    logic                 handshake;

    assign state_dbg = state;

    // Output decode, pop request and next-state selection.
    always_comb begin
        state_next = state;
        at_last    = (idx == LAST_IDX);
        out_valid  = reset && (state == SEND);
        handshake  = out_valid && out_ready;
        out_last   = out_valid && at_last;
        out_data   = out_valid ? sreg[SLICE_SIZE-1:0] : '0;
        busy       = reset && (state != IDLE);
        // The next word is popped either from IDLE or on the final-slice
        // transfer, which yields exactly one FETCH bubble between words.
        fifo_rd_en = reset && !fifo_empty &&
                     ((state == IDLE) || (handshake && at_last));
        case (state)
            IDLE: begin
                if (fifo_rd_en) state_next = FETCH;
            end
            FETCH: begin
                state_next = SEND;
            end
            SEND: begin
                if (handshake && at_last) state_next = fifo_rd_en ? FETCH : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register, shift register and slice index.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            idx   <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) begin
                // FIFO read data is valid during the FETCH cycle.
                sreg <= fifo_data;
                idx  <= '0;
            end else if (handshake && !at_last) begin
                sreg <= sreg >> SLICE_SIZE;
                idx  <= idx + IDX_W'(1);
            end
        end
    end

endmodule
